// File: rtl/div_pkg.sv
// Shared state encoding and default operand width for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational, no latency.
// No flow control; the caller decides when the result is registered.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;

    always_comb begin
        shifted = (rem_in << 1) | {{WIDTH{1'b0}}, next_bit};
        dvs_ext = {1'b0, divisor};
        q_bit   = (shifted >= dvs_ext);
        rem_out = q_bit ? (shifted - dvs_ext) : shifted;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle.
// Latency WIDTH+2 cycles from accept to result; divide-by-zero answers after 1 cycle.
// Accepts only when idle; result is held in DONE until out_ready is seen.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] dmag;
    logic             sgn_mode;
    logic             q_neg;
    logic             r_neg;
    logic             live;

    logic             accept;
    logic             zero_div;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   prem_nxt;
    logic             q_bit;

    always_comb begin
        accept       = in_valid && in_ready;
        zero_div     = (divisor == '0);
        dividend_mag = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (prem),
        .next_bit (qsr[WIDTH-1]),
        .divisor  (dmag),
        .rem_out  (prem_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // live gates in_ready so the block only advertises readiness after the first post-reset edge
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = live;
                if (in_valid && live) begin
                    state_nxt = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live        <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            qsr         <= '0;
            dmag        <= '0;
            sgn_mode    <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                sgn_mode <= in_signed;
                q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg    <= dividend[WIDTH-1];
                dmag     <= divisor_mag;
                qsr      <= dividend_mag;
                prem     <= '0;
                cnt      <= '0;
                if (zero_div) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == CALC) begin
                // qsr shifts dividend bits out of the top while quotient bits enter at the bottom
                prem <= prem_nxt;
                qsr  <= {qsr[WIDTH-2:0], q_bit};
                cnt  <= cnt + CW'(1);
            end else if (state == FIX) begin
                quotient    <= (sgn_mode && q_neg) ? -qsr : qsr;
                remainder   <= (sgn_mode && r_neg) ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit at WIDTH=16.
`timescale 1ns/1ps
module tb_div_unit;

    localparam int W = 16;
    localparam int NV = 10;

    localparam logic         V_S [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [W-1:0] V_A [NV] = '{16'hFFF9, 16'hFFF9, 16'h0007, 16'hFFF9, 16'h8000,
                                          16'hFFFF, 16'h0005, 16'h8000, 16'h0064, 16'hFF9C};
    localparam logic [W-1:0] V_B [NV] = '{16'h0002, 16'h0002, 16'hFFFE, 16'hFFFE, 16'hFFFF,
                                          16'h0001, 16'h0009, 16'hFFFF, 16'h0007, 16'h0007};
    localparam logic [W-1:0] V_Q [NV] = '{16'h7FFC, 16'hFFFD, 16'hFFFD, 16'h0003, 16'h8000,
                                          16'hFFFF, 16'h0000, 16'h0000, 16'h000E, 16'hFFF2};
    localparam logic [W-1:0] V_R [NV] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000,
                                          16'h0000, 16'h0005, 16'h8000, 16'h0002, 16'hFFFE};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Offer one operation, then scramble the operand inputs once it is taken.
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        in_signed = s;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        acc_cyc   = cyc;
        in_valid  = 1'b0;
        in_signed = ~s;
        dividend  = ~a;
        divisor   = b ^ 16'h5A5A;
    endtask

    // lat = number of edges after the accept edge until an edge that sees out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (quotient !== 16'h0000 || remainder !== 16'h0000) begin
            fails++; $display("FAIL reset_results got=%h/%h exp=0000/0000", quotient, remainder); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_early got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise got=%b exp=1", in_ready); end
    endtask

    task automatic test_unsigned_basic();
        int lat;
        start_op(1'b0, 16'd100, 16'd7);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL busy_out_valid got=%b exp=0", out_valid); end
        wait_result(lat);
        tests++; if (lat != 18) begin fails++; $display("FAIL u100_7_latency got=%0d exp=18", lat); end
        tests++; if (quotient !== 16'd14) begin fails++; $display("FAIL u100_7_q got=%h exp=000e", quotient); end
        tests++; if (remainder !== 16'd2) begin fails++; $display("FAIL u100_7_r got=%h exp=0002", remainder); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL u100_7_dbz got=%b exp=0", div_by_zero); end
        release_result();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL u100_7_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < NV; i++) begin
            start_op(V_S[i], V_A[i], V_B[i]);
            wait_result(lat);
            tests++; if (lat != 18) begin fails++; $display("FAIL vec%0d_latency got=%0d exp=18", i, lat); end
            tests++; if (quotient !== V_Q[i] || remainder !== V_R[i] || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_result got q=%h r=%h dbz=%b exp q=%h r=%h dbz=0",
                         i, quotient, remainder, div_by_zero, V_Q[i], V_R[i]);
            end
            release_result();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        for (int m = 0; m < 2; m++) begin
            start_op(m[0], 16'd1234, 16'd0);
            wait_result(lat);
            tests++; if (lat != 1) begin fails++; $display("FAIL dz%0d_latency got=%0d exp=1", m, lat); end
            tests++; if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_by_zero !== 1'b1) begin
                fails++;
                $display("FAIL dz%0d_result got q=%h r=%h dbz=%b exp q=ffff r=04d2 dbz=1",
                         m, quotient, remainder, div_by_zero);
            end
            release_result();
        end
        start_op(1'b1, 16'hFB2E, 16'd0);
        wait_result(lat);
        tests++; if (quotient !== 16'hFFFF || remainder !== 16'hFB2E || div_by_zero !== 1'b1) begin
            fails++;
            $display("FAIL dz_neg_result got q=%h r=%h dbz=%b exp q=ffff r=fb2e dbz=1",
                     quotient, remainder, div_by_zero);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        start_op(1'b0, 16'd100, 16'd7);
        wait_result(lat);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd14 ||
                remainder !== 16'd2 || div_by_zero !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
        release_result();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        int seen;
        start_op(1'b0, 16'd100, 16'd7);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== 16'h0000) begin
            fails++; $display("FAIL midrst_during got vld=%b rdy=%b q=%h exp vld=0 rdy=0 q=0000",
                              out_valid, in_ready, quotient); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_after got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL midrst_ghost got=%0d valid cycles exp=0", seen); end
        start_op(1'b0, 16'd9, 16'd3);
        wait_result(lat);
        tests++; if (quotient !== 16'd3 || remainder !== 16'd0 || lat != 18) begin
            fails++; $display("FAIL midrst_9_3 got q=%h r=%h lat=%0d exp q=0003 r=0000 lat=18",
                              quotient, remainder, lat); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        int a1;
        start_op(1'b0, 16'd100, 16'd7);
        a1 = acc_cyc;
        wait_result(lat);
        release_result();
        start_op(1'b1, 16'hFFF7, 16'd3);
        tests++; if (acc_cyc - a1 != 19) begin
            fails++; $display("FAIL b2b_spacing got=%0d exp=19", acc_cyc - a1); end
        wait_result(lat);
        tests++; if (quotient !== 16'hFFFD || remainder !== 16'h0000) begin
            fails++; $display("FAIL b2b_second got q=%h r=%h exp q=fffd r=0000", quotient, remainder); end
        release_result();
        start_op(1'b0, 16'd5, 16'd0);
        a1 = acc_cyc;
        wait_result(lat);
        release_result();
        start_op(1'b0, 16'd20, 16'd4);
        tests++; if (acc_cyc - a1 != 2) begin
            fails++; $display("FAIL b2b_dz_spacing got=%0d exp=2", acc_cyc - a1); end
        wait_result(lat);
        tests++; if (quotient !== 16'd5 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            fails++; $display("FAIL b2b_after_dz got q=%h r=%h dbz=%b exp q=0005 r=0000 dbz=0",
                              quotient, remainder, div_by_zero); end
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned_basic();
        test_vectors();
        test_div_zero();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; legal range is 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have port in_signed, input, 1 bit: 1 selects two's-complement operands; 0 selects unsigned.
REQ-007 The block SHALL have ports dividend and divisor, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have ports quotient and remainder, output, WIDTH bits each: the results.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: the presented result came from a zero divisor.

Function
REQ-012 The block SHALL implement four states: IDLE, CALC, FIX and DONE.
REQ-013 The block SHALL drive in_ready high only in IDLE; an accept is a rising edge with in_valid && in_ready.
REQ-014 On accept, the block SHALL capture operand magnitudes, in_signed, the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign); signs are used only when in_signed=1.
REQ-015 On accept with divisor==0, the block SHALL go directly to DONE with quotient = all ones, remainder = dividend unchanged and div_by_zero=1, giving out_valid one cycle after accept.
REQ-016 On accept with a nonzero divisor, the block SHALL go to CALC with the iteration counter at 0, the partial remainder (WIDTH+1 bits) at 0 and the quotient shift register at |dividend|.
REQ-017 In each CALC cycle the block SHALL perform one restoring step, MSB first: shift the partial remainder left and insert the next dividend bit; if the result is >= |divisor|, subtract and shift in quotient bit 1, else shift in 0.
REQ-018 After exactly WIDTH CALC cycles the block SHALL go to FIX, where it negates the quotient if the quotient sign is set and negates the remainder if the remainder sign is set (signed mode only), then goes to DONE.
REQ-019 The block SHALL produce out_valid WIDTH+2 cycles after accept for a nonzero divisor, independent of operand values.
REQ-020 Signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend; MIN / -1 SHALL give quotient=MIN and remainder=0, with no flag.
REQ-021 In DONE the block SHALL hold out_valid=1 and keep quotient, remainder and div_by_zero stable until out_ready=1, then return to IDLE on that edge.
REQ-022 The block SHALL NOT accept an operation on the edge that leaves DONE; the minimum accept-to-accept spacing is WIDTH+3 cycles (2 cycles for divide-by-zero).
REQ-023 The block SHALL keep out_valid=0 in IDLE, CALC and FIX; quotient and remainder hold their last presented values outside DONE.
REQ-024 Changes to in_valid or any input operand after accept SHALL have no effect on the operation in flight.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE, with quotient=0, remainder=0, div_by_zero=0, out_valid=0, the counter at 0 and all internal registers at 0.
REQ-026 When rst_n asserts during CALC, FIX or DONE, the block SHALL abandon the operation immediately; no result is ever presented for it.
REQ-027 The block SHALL raise in_ready on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package div_pkg SHALL hold the state enumeration (IDLE, CALC, FIX, DONE) and the default WIDTH constant.
REQ-029 Sub-module div_step SHALL hold the combinational single restoring step (WIDTH+1-bit compare/subtract, quotient bit out), instantiated once.
REQ-030 The counter width SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=16)
REQ-031 Unsigned 100/7 SHALL give out_valid 18 cycles after accept with quotient=14, remainder=2 and div_by_zero=0.
REQ-032 Signed -7/2 (0xFFF9/0x0002) SHALL give quotient=0xFFFD and remainder=0xFFFF; unsigned 0xFFF9/2 SHALL give quotient=0x7FFC and remainder=1.
REQ-033 1234/0 (either mode) SHALL give out_valid one cycle after accept with quotient=0xFFFF, remainder=1234 and div_by_zero=1.
REQ-034 Signed 0x8000/0xFFFF SHALL give quotient=0x8000 and remainder=0.
REQ-035 With out_ready held low for 5 cycles in DONE, outputs SHALL stay stable and in_ready=0 throughout; the block SHALL return to IDLE one edge after out_ready rises.
REQ-036 rst_n pulsed low at CALC cycle 8 SHALL yield out_valid=0 and in_ready=1 after release; a following 9/3 SHALL give quotient=3 and remainder=0.
